// File: rtl/bcd_display_counter.sv
// Four-digit BCD up/down counter advanced by synchronised slow_clk rising edges; drives four 7-seg displays.
// Count updates 2 edges after slow_clk is first sampled high (1 edge after load); hex follows count by 1 edge.
module bcd_display_counter #(
  parameter bit LEADING_ZERO_BLANK = 1'b0
) (
  input  logic        clock_50MHZ,
  input  logic        rst_n,
  input  logic        slow_clk,
  input  logic        enable,
  input  logic        up_down,
  input  logic        load,
  input  logic [15:0] load_value,
  output logic [15:0] count,
  output logic        wrap,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3
);

  logic        s1_q, s2_q, s3_q;
  logic [1:0]  arm_cnt_q, arm_cnt_d;
  logic        armed;
  logic        tick;
  logic [15:0] count_q, count_d;
  logic        wrap_q, wrap_d;
  logic [27:0] hex_q, hex_d;
  logic [16:0] step_res;

  function automatic logic [15:0] sanitize(input logic [15:0] v);
    logic [15:0] r;
    r = v;
    for (int i = 0; i < 4; i++) begin
      if (v[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd0;
    end
    return r;
  endfunction

  // Returns {wrapped, next}; the ripple carry/borrow surviving all four digits means wrap.
  function automatic logic [16:0] bcd_step(input logic [15:0] v, input logic up);
    logic [15:0] r;
    logic        c;
    logic [3:0]  d;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d = v[4*i +: 4];
      if (c) begin
        if (up) begin
          if (d == 4'd9) begin
            r[4*i +: 4] = 4'd0;
          end else begin
            r[4*i +: 4] = d + 4'd1;
            c = 1'b0;
          end
        end else begin
          if (d == 4'd0) begin
            r[4*i +: 4] = 4'd9;
          end else begin
            r[4*i +: 4] = d - 4'd1;
            c = 1'b0;
          end
        end
      end
    end
    return {c, r};
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  function automatic logic [27:0] display(input logic [15:0] v);
    logic [3:0]  blank;
    logic [27:0] r;
    blank = '0;
    if (LEADING_ZERO_BLANK) begin
      blank[3] = (v[15:12] == 4'd0);
      blank[2] = blank[3] && (v[11:8] == 4'd0);
      blank[1] = blank[2] && (v[7:4] == 4'd0);
    end
    r = '0;
    for (int i = 0; i < 4; i++) begin
      r[7*i +: 7] = blank[i] ? 7'h7F : seg7(v[4*i +: 4]);
    end
    return r;
  endfunction

  function automatic logic bcd_valid(input logic [15:0] v);
    return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (v[11:8] <= 4'd9) && (v[15:12] <= 4'd9);
  endfunction

  // The arm delay keeps a slow_clk already high through reset from looking like a fresh edge.
  assign armed     = (arm_cnt_q == 2'd3);
  assign arm_cnt_d = armed ? arm_cnt_q : arm_cnt_q + 2'd1;
  assign tick      = s2_q & ~s3_q & armed;

  always_comb begin
    count_d  = count_q;
    wrap_d   = 1'b0;
    step_res = bcd_step(count_q, up_down);
    if (load) begin
      count_d = sanitize(load_value);
    end else if (tick && enable) begin
      count_d = step_res[15:0];
      wrap_d  = step_res[16];
    end
  end

  assign hex_d = display(count_q);

  always_ff @(posedge clock_50MHZ) begin
    if (!rst_n) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      s3_q      <= 1'b0;
      arm_cnt_q <= 2'd0;
      count_q   <= 16'h0000;
      wrap_q    <= 1'b0;
      hex_q     <= display(16'h0000);
    end else begin
      s1_q      <= slow_clk;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
      arm_cnt_q <= arm_cnt_d;
      count_q   <= count_d;
      wrap_q    <= wrap_d;
      hex_q     <= hex_d;
    end
  end

  assign count = count_q;
  assign wrap  = wrap_q;
  assign hex0  = hex_q[6:0];
  assign hex1  = hex_q[13:7];
  assign hex2  = hex_q[20:14];
  assign hex3  = hex_q[27:21];

  nibbles_valid: assert property (@(posedge clock_50MHZ) disable iff (!rst_n) bcd_valid(count_q));

endmodule

// File: tb/tb_bcd_display_counter.sv
// Directed bench for bcd_display_counter: integer-valued reference model checked every cycle, plus literal pins.
module tb_bcd_display_counter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        slow_clk = 1'b1;
  logic        enable = 1'b1;
  logic        up_down = 1'b1;
  logic        load = 1'b0;
  logic [15:0] load_value = 16'h0000;

  logic [15:0] count_a, count_b;
  logic        wrap_a, wrap_b;
  logic [6:0]  h0a, h1a, h2a, h3a, h0b, h1b, h2b, h3b;

  int errors = 0;
  int checks = 0;

  localparam logic [6:0] SEG [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                      7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  localparam int P10 [4] = '{1, 10, 100, 1000};

  bcd_display_counter #(.LEADING_ZERO_BLANK(1'b0)) dut_a (
    .clock_50MHZ(clk), .rst_n(rst_n), .slow_clk(slow_clk), .enable(enable),
    .up_down(up_down), .load(load), .load_value(load_value),
    .count(count_a), .wrap(wrap_a), .hex0(h0a), .hex1(h1a), .hex2(h2a), .hex3(h3a)
  );

  bcd_display_counter #(.LEADING_ZERO_BLANK(1'b1)) dut_b (
    .clock_50MHZ(clk), .rst_n(rst_n), .slow_clk(slow_clk), .enable(enable),
    .up_down(up_down), .load(load), .load_value(load_value),
    .count(count_b), .wrap(wrap_b), .hex0(h0b), .hex1(h1b), .hex2(h2b), .hex3(h3b)
  );

  always #10 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic int from_load(input logic [15:0] lv);
    int v, d;
    v = 0;
    for (int n = 0; n < 4; n++) begin
      d = int'((lv >> (4 * n)) & 16'hF);
      if (d > 9) d = 0;
      v += d * P10[n];
    end
    return v;
  endfunction

  function automatic logic [6:0] exp_seg(input int v, input int n, input bit blank);
    if (blank && n > 0 && v < P10[n]) return 7'h7F;
    return SEG[(v / P10[n]) % 10];
  endfunction

  // Reference model: count as a plain integer, slow_clk as a history of per-edge samples.
  int m_count = 0;
  int m_disp  = 0;
  bit m_wrap  = 1'b0;
  bit samp1 = 1'b0, samp2 = 1'b0, samp3 = 1'b0;
  int good_edges = 0;
  bit model_live = 1'b0;

  always @(posedge clk) begin
    bit m_tick;
    model_live = 1'b1;
    if (!rst_n) begin
      m_count = 0; m_disp = 0; m_wrap = 1'b0;
      samp1 = 1'b0; samp2 = 1'b0; samp3 = 1'b0;
      good_edges = 0;
    end else begin
      m_tick = samp2 && !samp3 && (good_edges >= 3);
      m_disp = m_count;
      m_wrap = 1'b0;
      if (load) begin
        m_count = from_load(load_value);
      end else if (m_tick && enable) begin
        if (up_down) begin
          m_wrap  = (m_count == 9999);
          m_count = (m_count + 1) % 10000;
        end else begin
          m_wrap  = (m_count == 0);
          m_count = (m_count + 9999) % 10000;
        end
      end
      samp3 = samp2; samp2 = samp1; samp1 = slow_clk;
      if (good_edges < 3) good_edges++;
    end
  end

  always begin
    @(posedge clk);
    #2;
    if (model_live) begin
      chk("count_a", 32'(count_a), 32'(to_bcd(m_count)));
      chk("count_b", 32'(count_b), 32'(to_bcd(m_count)));
      chk("wrap_a", 32'(wrap_a), 32'(m_wrap));
      chk("wrap_b", 32'(wrap_b), 32'(m_wrap));
      chk("hex0_a", 32'(h0a), 32'(exp_seg(m_disp, 0, 1'b0)));
      chk("hex1_a", 32'(h1a), 32'(exp_seg(m_disp, 1, 1'b0)));
      chk("hex2_a", 32'(h2a), 32'(exp_seg(m_disp, 2, 1'b0)));
      chk("hex3_a", 32'(h3a), 32'(exp_seg(m_disp, 3, 1'b0)));
      chk("hex0_b", 32'(h0b), 32'(exp_seg(m_disp, 0, 1'b1)));
      chk("hex1_b", 32'(h1b), 32'(exp_seg(m_disp, 1, 1'b1)));
      chk("hex2_b", 32'(h2b), 32'(exp_seg(m_disp, 2, 1'b1)));
      chk("hex3_b", 32'(h3b), 32'(exp_seg(m_disp, 3, 1'b1)));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic give_edge();
    slow_clk = 1'b1; step(4);
    slow_clk = 1'b0; step(4);
  endtask

  task automatic do_load(input logic [15:0] v);
    load = 1'b1; load_value = v; step(1);
    load = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    step(3);
    chk("reset_count", 32'(count_a), 32'h0000);
    chk("reset_wrap", 32'(wrap_a), 32'h0);
    chk("reset_hex0", 32'(h0a), 32'h40);
    chk("reset_hex3_blank", 32'(h3b), 32'h7F);

    // slow_clk high across reset must not count
    rst_n = 1'b1; step(10);
    chk("post_rst_count", 32'(count_a), 32'h0000);
    chk("post_rst_hex", 32'({h3a, h2a, h1a, h0a}), 32'({7'h40, 7'h40, 7'h40, 7'h40}));
    slow_clk = 1'b0; step(5);
    slow_clk = 1'b1; step(2);
    chk("first_edge_k1", 32'(count_a), 32'h0000);
    step(1);
    chk("first_edge_k2", 32'(count_a), 32'h0001);
    chk("first_edge_hex_old", 32'(h0a), 32'h40);
    step(1);
    chk("first_edge_hex0", 32'(h0a), 32'h79);
    slow_clk = 1'b0; step(4);

    do_load(16'h9998);
    chk("load_9998", 32'(count_a), 32'h9998);
    give_edge();
    chk("up_9999", 32'(count_a), 32'h9999);
    slow_clk = 1'b1; step(3);
    chk("up_wrap_cnt", 32'(count_a), 32'h0000);
    chk("up_wrap_pulse", 32'(wrap_a), 32'h1);
    step(1);
    chk("up_wrap_end", 32'(wrap_a), 32'h0);
    slow_clk = 1'b0; step(4);

    up_down = 1'b0;
    do_load(16'h1000);
    give_edge();
    chk("down_borrow", 32'(count_a), 32'h0999);
    do_load(16'h0000);
    slow_clk = 1'b1; step(3);
    chk("down_wrap_cnt", 32'(count_a), 32'h9999);
    chk("down_wrap_pulse", 32'(wrap_a), 32'h1);
    step(1);
    chk("down_wrap_end", 32'(wrap_a), 32'h0);
    slow_clk = 1'b0; step(4);

    // load lands on the tick cycle and must win
    up_down = 1'b1;
    slow_clk = 1'b1; step(2);
    do_load(16'h12A4);
    chk("load_prio", 32'(count_a), 32'h1204);
    chk("load_prio_wrap", 32'(wrap_a), 32'h0);
    step(1);
    chk("load_prio_hold", 32'(count_a), 32'h1204);
    chk("load_prio_hex", 32'({h3a, h2a, h1a, h0a}), 32'({7'h79, 7'h24, 7'h40, 7'h19}));
    slow_clk = 1'b0; step(4);

    enable = 1'b0;
    repeat (3) give_edge();
    chk("enable_hold", 32'(count_a), 32'h1204);
    enable = 1'b1;
    repeat (2) give_edge();
    chk("enable_plus2", 32'(count_a), 32'h1206);

    // direction flips away from the tick must not matter
    up_down = 1'b0; step(1);
    up_down = 1'b1; give_edge();
    chk("dir_sampled", 32'(count_a), 32'h1207);

    slow_clk = 1'b1; step(2);
    rst_n = 1'b0; step(1);
    rst_n = 1'b1;
    chk("mid_reset_count", 32'(count_a), 32'h0000);
    chk("mid_reset_wrap", 32'(wrap_a), 32'h0);
    step(1);
    chk("mid_reset_no_tick", 32'(count_a), 32'h0000);
    slow_clk = 1'b0; step(4);

    do_load(16'h0050);
    chk("blank_count", 32'(count_b), 32'h0050);
    step(1);
    chk("blank_hex", 32'({h3b, h2b, h1b, h0b}), 32'({7'h7F, 7'h7F, 7'h12, 7'h40}));
    chk("noblank_hex", 32'({h3a, h2a, h1a, h0a}), 32'({7'h40, 7'h40, 7'h12, 7'h40}));
    step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
